// File: rtl/cpu_run_controller.sv
// ============================================================================
// Module   : cpu_run_controller
// Brief    : Run-state sequencer gating PC advance and architectural writes
//            for multi-cycle MULT/DIV, acknowledged OUTPUT and HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_run_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic       halt_i,
  input  logic       output_flag_i,
  input  logic [3:0] alu_ctr_i,
  input  logic       reg_write_i,
  input  logic       mem_write_i,
  input  logic       out_ack_i,
  output logic       pc_en_o,
  output logic       reg_write_en_o,
  output logic       mem_write_en_o,
  output logic       alu_busy_o,
  output logic       out_valid_o,
  output logic       halted_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_MULDIV   = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  localparam logic [3:0] C_ALU_MULT = 4'b1000;
  localparam logic [3:0] C_ALU_DIV  = 4'b1001;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               w_is_mul, w_is_div;

  assign w_is_mul = (alu_ctr_i == C_ALU_MULT);
  assign w_is_div = (alu_ctr_i == C_ALU_DIV);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_en_o        = 1'b0;
    reg_write_en_o = 1'b0;
    mem_write_en_o = 1'b0;
    alu_busy_o     = 1'b0;
    out_valid_o    = 1'b0;
    halted_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_RUN;
      end

      S_RUN: begin
        if (halt_i) begin
          state_d = S_HALTED;
        end else if (output_flag_i) begin
          state_d = S_OUT_WAIT;
        end else if (w_is_mul || w_is_div) begin
          // The RUN cycle counts as cycle 1, so MULDIV lasts N-1 cycles.
          cnt_d   = w_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
          state_d = S_MULDIV;
        end else begin
          pc_en_o        = 1'b1;
          reg_write_en_o = reg_write_i;
          mem_write_en_o = mem_write_i;
        end
      end

      S_MULDIV: begin
        alu_busy_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_en_o        = 1'b1;
          reg_write_en_o = reg_write_i;
          state_d        = S_RUN;
        end
      end

      S_OUT_WAIT: begin
        out_valid_o = 1'b1;
        if (out_ack_i) begin
          pc_en_o = 1'b1;
          state_d = S_RUN;
        end
      end

      S_HALTED: begin
        halted_o = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
// ============================================================================
// Module   : tb_cpu_run_controller
// Brief    : Directed plus random stimulus checked every cycle against an
//            instruction-level reference model of the run controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_controller;

  localparam int MUL_N = 4;
  localparam int DIV_N = 16;

  logic       clk = 1'b0;
  logic       rst, run, hlt, outf, rw, mw, ack;
  logic [3:0] alu;
  logic       pc_en, rw_en, mw_en, busy, ov, halted;
  logic [2:0] st;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase (0 idle,1 run,2 muldiv,3 out wait,4 halted) and the number
  // of cycles the current multi-cycle instruction still has to occupy.
  int m_phase = 0;
  int m_left  = 0;
  logic last_pc;

  always #5 clk = ~clk;

  cpu_run_controller #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(5)) dut (
    .clock_i(clk), .reset_i(rst), .run_i(run), .halt_i(hlt),
    .output_flag_i(outf), .alu_ctr_i(alu), .reg_write_i(rw),
    .mem_write_i(mw), .out_ack_i(ack), .pc_en_o(pc_en),
    .reg_write_en_o(rw_en), .mem_write_en_o(mw_en), .alu_busy_o(busy),
    .out_valid_o(ov), .halted_o(halted), .state_o(st)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic i_rst, i_run, i_hlt, i_outf,
                      input logic [3:0] i_alu, input logic i_rw, i_mw, i_ack);
    logic e_pc, e_rw, e_mw, e_busy, e_ov, e_h;
    int   n_phase, n_left;
    @(negedge clk);
    rst = i_rst; run = i_run; hlt = i_hlt; outf = i_outf;
    alu = i_alu; rw = i_rw; mw = i_mw; ack = i_ack;
    #1;
    {e_pc, e_rw, e_mw, e_busy, e_ov, e_h} = '0;
    n_phase = m_phase;
    n_left  = m_left;
    if (m_phase == 0) begin
      if (i_run) n_phase = 1;
    end else if (m_phase == 1) begin
      if (i_hlt) n_phase = 4;
      else if (i_outf) n_phase = 3;
      else if (i_alu == 4'b1000 || i_alu == 4'b1001) begin
        n_phase = 2;
        n_left  = ((i_alu == 4'b1001) ? DIV_N : MUL_N) - 1;
      end else begin
        e_pc = 1'b1; e_rw = i_rw; e_mw = i_mw;
      end
    end else if (m_phase == 2) begin
      e_busy = 1'b1;
      if (m_left == 1) begin
        e_pc = 1'b1; e_rw = i_rw; n_phase = 1;
      end
      n_left = m_left - 1;
    end else if (m_phase == 3) begin
      e_ov = 1'b1;
      if (i_ack) begin
        e_pc = 1'b1; n_phase = 1;
      end
    end else begin
      e_h = 1'b1;
    end
    check("state",  st, 3'(m_phase));
    check("pc_en",  {2'b0, pc_en}, {2'b0, e_pc});
    check("rw_en",  {2'b0, rw_en}, {2'b0, e_rw});
    check("mw_en",  {2'b0, mw_en}, {2'b0, e_mw});
    check("busy",   {2'b0, busy},  {2'b0, e_busy});
    check("outval", {2'b0, ov},    {2'b0, e_ov});
    check("halted", {2'b0, halted}, {2'b0, e_h});
    last_pc = pc_en;
    @(posedge clk);
    if (i_rst) begin
      m_phase = 0; m_left = 0;
    end else begin
      m_phase = n_phase; m_left = n_left;
    end
  endtask

  // Shorthand for a plain instruction cycle with no control flags.
  task automatic nop(input logic [3:0] a, input logic r, input logic m);
    step(1'b0, 1'b0, 1'b0, 1'b0, a, r, m, 1'b0);
  endtask

  initial begin
    int cyc;
    int ov_cnt;
    rst = 1'b1; run = 1'b0; hlt = 1'b0; outf = 1'b0;
    alu = 4'b0; rw = 1'b0; mw = 1'b0; ack = 1'b0;
    m_phase = 0;

    // Reset and start, then an ADD commits in the cycle after run.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    nop(4'b0010, 1'b1, 1'b0);
    check("add_pc", {2'b0, last_pc}, 3'd1);

    // MULT: commit on cycle 4.
    cyc = 0;
    do begin nop(4'b1000, 1'b1, 1'b1); cyc++; end while (!last_pc && cyc < 40);
    check("mul_lat", 3'(cyc), 3'(MUL_N));

    // DIV: commit on cycle 16 (alu_ctr changed mid-way is not re-sampled).
    cyc = 0;
    do begin nop((cyc < 2) ? 4'b1001 : 4'b0010, 1'b1, 1'b0); cyc++; end
    while (!last_pc && cyc < 40);
    n_checks++;
    assert (cyc == DIV_N) n_pass++;
    else $error("FAIL div_lat observed=%0d expected=%0d", cyc, DIV_N);

    // OUTPUT: ack low five cycles then high; out_valid spans six cycles.
    ov_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, (i == 5));
      if (ov) ov_cnt++;
    end
    n_checks++;
    assert (ov_cnt == 6) n_pass++;
    else $error("FAIL ov_len observed=%0d expected=6", ov_cnt);
    nop(4'b0, 1'b0, 1'b0);

    // OUTPUT with ack already high on entry completes in one wait cycle.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    nop(4'b0, 1'b0, 1'b0);

    // HALT with mem_write; stays frozen while run/out_ack toggle.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, i[0], 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, ~i[0]);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    nop(4'b0, 1'b0, 1'b0);

    // Reset in MULDIV cycle 2, and reset in OUT_WAIT.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    nop(4'b1000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
    nop(4'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1);
    nop(4'b0, 1'b1, 1'b1);

    // halt and output_flag together: halt wins, out_valid never rises.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets, more likely once halted.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      case ($urandom_range(0, 3))
        0:       a = 4'b1000;
        1:       a = 4'b1001;
        default: a = 4'($urandom);
      endcase
      step(((m_phase == 4) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 150) == 0),
           1'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 8) == 0),
           a, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
